// File: rtl/dmem_responder.sv
// Data-memory responder: a word RAM fronted by a posted write buffer that
// drains in the background, plus a fixed-latency read path. Reads are held
// off until the buffer is empty, so a read always observes every earlier
// accepted write. Misaligned accesses are flagged on AdrErr instead of
// touching RAM.
module dmem_responder #(
    parameter int DEPTH = 64,
    parameter int WAIT  = 2,
    parameter int WCYC  = 2,
    parameter int WBUF  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic        MemReady,
    output logic [31:0] ReadData,
    output logic        ReadValid,
    output logic        AdrErr
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(WBUF);
    localparam int CW = BW + 1;

    // Occupancy at which the write buffer refuses further writes.
    localparam logic [CW-1:0] BUF_FULL   = CW'(WBUF);
    // Last value of the read wait counter before the response cycle.
    localparam logic [3:0]    WAIT_LAST  = 4'((WAIT > 0) ? (WAIT - 1) : 0);
    // Last value of the drain counter; the head entry retires on it.
    localparam logic [3:0]    DRAIN_LAST = 4'(WCYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        RWAIT,
        RRESP
    } state_t;

    // Storage, reachable hierarchically as dut.RAM
    logic [31:0]   RAM [0:DEPTH-1];

    // Write buffer: circular queue of {word index, data}
    logic [AW-1:0] r_bufIdx  [0:WBUF-1];
    logic [31:0]   r_bufData [0:WBUF-1];
    logic [BW-1:0] r_wrPtr;
    logic [BW-1:0] r_rdPtr;
    logic [CW-1:0] r_bufCount;
    logic [3:0]    r_drainCnt;

    // Read-side control
    state_t        r_state;
    state_t        w_nextState;
    logic [3:0]    r_waitCnt;
    logic [AW-1:0] r_rdIdx;
    logic          r_rdMis;

    // Registered outputs
    logic [31:0]   r_readData;
    logic          r_readValid;
    logic          r_adrErr;

    // Decoded request fields and handshake terms
    logic [AW-1:0] w_idx;
    logic          w_misaligned;
    logic          w_bufEmpty;
    logic          w_acceptWrite;
    logic          w_acceptRead;
    logic          w_enqueue;
    logic          w_pop;
    logic          w_loadResp;
    logic [AW-1:0] w_respIdx;
    logic          w_respMis;
    logic          w_unusedAdr;

    // Upper address bits alias onto the same words and are deliberately ignored.
    assign w_unusedAdr   = ^DataAdr[31:AW+2];

    assign w_idx         = DataAdr[AW+1:2];
    assign w_misaligned  = |DataAdr[1:0];
    assign w_bufEmpty    = (r_bufCount == '0);
    assign w_acceptWrite = MemReady & MemWrite;
    assign w_acceptRead  = MemReady & ~MemWrite;
    assign w_enqueue     = w_acceptWrite & ~w_misaligned;
    assign w_pop         = ~w_bufEmpty & (r_drainCnt == DRAIN_LAST);

    // The read index comes straight off the bus when the response follows the
    // accept cycle directly (no wait states); otherwise it comes from the latch.
    assign w_loadResp    = (w_nextState == RRESP) && (r_state != RRESP);
    assign w_respIdx     = (r_state == IDLE) ? w_idx : r_rdIdx;
    assign w_respMis     = (r_state == IDLE) ? w_misaligned : r_rdMis;

    assign ReadData      = r_readData;
    assign ReadValid     = r_readValid;
    assign AdrErr        = r_adrErr;

    // Next-state and handshake: only IDLE accepts, writes need a free slot,
    // reads need an empty buffer, and nothing is accepted while in reset.
    always_comb begin
        w_nextState = r_state;
        MemReady    = 1'b0;
        case (r_state)
            IDLE: begin
                if (MemReq && !reset) begin
                    if (MemWrite) begin
                        MemReady = (r_bufCount < BUF_FULL);
                    end else begin
                        MemReady = w_bufEmpty;
                    end
                end
                if (w_acceptRead) begin
                    w_nextState = (WAIT > 0) ? RWAIT : RRESP;
                end
            end
            RWAIT: begin
                if (r_waitCnt == WAIT_LAST) begin
                    w_nextState = RRESP;
                end
            end
            RRESP: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Counts wait states while a read sits in RWAIT; cleared everywhere else.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_waitCnt <= '0;
        end else if (r_state == RWAIT && w_nextState == RWAIT) begin
            r_waitCnt <= r_waitCnt + 4'd1;
        end else begin
            r_waitCnt <= '0;
        end
    end

    // Latch the word index and alignment of an accepted read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdIdx <= '0;
            r_rdMis <= 1'b0;
        end else if (w_acceptRead) begin
            r_rdIdx <= w_idx;
            r_rdMis <= w_misaligned;
        end
    end

    // Response registers: data and valid are loaded entering RRESP, so the
    // pulse lasts exactly the RRESP cycle and ReadData holds until the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readData  <= '0;
            r_readValid <= 1'b0;
        end else begin
            r_readValid <= w_loadResp;
            if (w_loadResp) begin
                r_readData <= w_respMis ? 32'h0 : RAM[w_respIdx];
            end
        end
    end

    // AdrErr pulses the cycle after a misaligned write is accepted, or
    // alongside ReadValid for a misaligned read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_adrErr <= 1'b0;
        end else begin
            r_adrErr <= (w_acceptWrite & w_misaligned) | (w_loadResp & w_respMis);
        end
    end

    // Buffer pointers and occupancy; a simultaneous push and pop cancel out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_bufCount <= '0;
        end else begin
            if (w_enqueue) begin
                r_wrPtr <= r_wrPtr + BW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + BW'(1);
            end
            case ({w_enqueue, w_pop})
                2'b10:   r_bufCount <= r_bufCount + CW'(1);
                2'b01:   r_bufCount <= r_bufCount - CW'(1);
                default: r_bufCount <= r_bufCount;
            endcase
        end
    end

    // Drain timer: counts cycles spent on the current head entry and restarts
    // when it retires, so each new head gets a full WCYC cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drainCnt <= '0;
        end else if (w_pop || w_bufEmpty) begin
            r_drainCnt <= '0;
        end else begin
            r_drainCnt <= r_drainCnt + 4'd1;
        end
    end

    // Buffer payload and RAM write-back; neither is cleared by reset so RAM
    // keeps its contents and stale buffer slots are simply ignored.
    always_ff @(posedge clk) begin
        if (w_enqueue) begin
            r_bufIdx[r_wrPtr]  <= w_idx;
            r_bufData[r_wrPtr] <= WriteData;
        end
        if (w_pop) begin
            RAM[r_bufIdx[r_rdPtr]] <= r_bufData[r_rdPtr];
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder. A transaction-level model keeps a
// queue of posted writes, each tagged with the cycle at which it retires,
// and a single pending read with its due cycle.
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int WAIT  = 2;
    localparam int WCYC  = 2;
    localparam int WBUF  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReq;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        MemReady;
    logic [31:0] ReadData;
    logic        ReadValid;
    logic        AdrErr;

    int checks   = 0;
    int failures = 0;

    dmem_responder #(
        .DEPTH(DEPTH),
        .WAIT (WAIT),
        .WCYC (WCYC),
        .WBUF (WBUF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .MemReq   (MemReq),
        .MemWrite (MemWrite),
        .DataAdr  (DataAdr),
        .WriteData(WriteData),
        .MemReady (MemReady),
        .ReadData (ReadData),
        .ReadValid(ReadValid),
        .AdrErr   (AdrErr)
    );

    always #5 clk = ~clk;

    // Reference model state
    typedef struct {
        int          idx;
        logic [31:0] data;
        int          popAt;
    } wentry_t;

    wentry_t     wq[$];
    logic [31:0] mram [0:DEPTH-1];
    int          cyc = 0;
    int          lastPop = -1;
    int          errDue = -1;
    int          rdDue = 0;
    int          rdIdx = 0;
    bit          rdPending = 0;
    bit          rdMis = 0;

    logic        expReady, expValid, expErr;
    logic [31:0] expData = 32'h0;
    logic        obsReady, obsValid, obsErr;
    logic [31:0] obsData;

    function automatic int wordOf(input logic [31:0] adr);
        return int'((adr >> 2) % 32'(DEPTH));
    endfunction

    task automatic modelReset();
        wq.delete();
        rdPending = 0;
        errDue    = -1;
        lastPop   = -1;
        expData   = 32'h0;
    endtask

    // Drives one bus cycle, snapshots DUT outputs mid-cycle next to the model's
    // expectations, then advances the model past the clock edge.
    task automatic driveCycle(input logic req, input logic wr,
                              input logic [31:0] adr, input logic [31:0] data);
        wentry_t e;
        MemReq    = req;
        MemWrite  = wr;
        DataAdr   = adr;
        WriteData = data;
        @(negedge clk);
        expReady = !rdPending && req && (wr ? (wq.size() < WBUF) : (wq.size() == 0));
        expValid = rdPending && (cyc == rdDue);
        expErr   = (errDue == cyc) || (expValid && rdMis);
        if (expValid) expData = rdMis ? 32'h0 : mram[rdIdx];
        obsReady = MemReady;
        obsValid = ReadValid;
        obsErr   = AdrErr;
        obsData  = ReadData;
        @(posedge clk);
        if (wq.size() > 0 && wq[0].popAt == cyc) begin
            mram[wq[0].idx] = wq[0].data;
            wq.delete(0);
        end
        if (expValid) rdPending = 0;
        if (expReady && wr) begin
            if (adr[1:0] != 2'b00) begin
                errDue = cyc + 1;
            end else begin
                e.idx   = wordOf(adr);
                e.data  = data;
                e.popAt = ((cyc > lastPop) ? cyc : lastPop) + WCYC;
                lastPop = e.popAt;
                wq.push_back(e);
            end
        end
        if (expReady && !wr) begin
            rdPending = 1;
            rdDue     = cyc + WAIT + 1;
            rdIdx     = wordOf(adr);
            rdMis     = (adr[1:0] != 2'b00);
        end
        cyc++;
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) driveCycle(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic applyReset();
        reset  = 1'b1;
        MemReq = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
    endtask

    task automatic test_reset();
        reset = 1'b1; MemReq = 1'b1; MemWrite = 1'b0; DataAdr = 32'h0; WriteData = 32'h0;
        #3;
        checks++; if (MemReady !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got=%b want=0", MemReady); end
        checks++; if (ReadValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b want=0", ReadValid); end
        checks++; if (AdrErr !== 1'b0) begin failures++; $display("[TB] FAIL reset_adrerr got=%b want=0", AdrErr); end
        checks++; if (ReadData !== 32'h0) begin failures++; $display("[TB] FAIL reset_data got=%h want=0", ReadData); end
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++; if (MemReady !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready_held got=%b want=0", MemReady); end
        reset  = 1'b0;
        MemReq = 1'b0;
        modelReset();
    endtask

    task automatic test_preload();
        logic [31:0] d;
        int guard;
        for (int i = 0; i < DEPTH; i++) begin
            d = $urandom;
            guard = 0;
            do begin
                driveCycle(1'b1, 1'b1, 32'(i * 4), d);
                checks++; if (obsReady !== expReady) begin failures++; $display("[TB] FAIL preload_ready word=%0d got=%b want=%b", i, obsReady, expReady); end
                guard++;
            end while (!expReady && guard < 20);
        end
        settle(10);
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (dut.RAM[i] !== mram[i]) begin failures++; $display("[TB] FAIL preload_ram word=%0d got=%h want=%h", i, dut.RAM[i], mram[i]); end
        end
    endtask

    task automatic test_single_write();
        logic [31:0] old24;
        settle(4);
        old24 = mram[24];
        driveCycle(1'b1, 1'b1, 32'h60, 32'h7);
        checks++; if (obsReady !== 1'b1) begin failures++; $display("[TB] FAIL single_ready got=%b want=1", obsReady); end
        checks++; if (dut.RAM[24] !== old24) begin failures++; $display("[TB] FAIL single_early1 got=%h want=%h", dut.RAM[24], old24); end
        driveCycle(1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (dut.RAM[24] !== old24) begin failures++; $display("[TB] FAIL single_early2 got=%h want=%h", dut.RAM[24], old24); end
        driveCycle(1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (dut.RAM[24] !== 32'h7) begin failures++; $display("[TB] FAIL single_written got=%h want=7", dut.RAM[24]); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  readyPat;
        logic [31:0] dat [0:7];
        logic [31:0] old25;
        int n;
        settle(4);
        readyPat = 8'b1011_1111;
        old25 = mram[25];
        for (int k = 0; k < 8; k++) dat[k] = $urandom;
        dat[1] = ~old25;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            driveCycle(1'b1, 1'b1, 32'h60 + 32'(4 * n), dat[n]);
            checks++; if (obsReady !== readyPat[k]) begin failures++; $display("[TB] FAIL b2b_ready cycle=%0d got=%b want=%b", k, obsReady, readyPat[k]); end
            if (expReady) n++;
            if (k == 2) begin
                checks++; if (dut.RAM[24] !== dat[0]) begin failures++; $display("[TB] FAIL b2b_pop1 got=%h want=%h", dut.RAM[24], dat[0]); end
                checks++; if (dut.RAM[25] !== old25) begin failures++; $display("[TB] FAIL b2b_nopop2 got=%h want=%h", dut.RAM[25], old25); end
            end
            if (k == 4) begin
                checks++; if (dut.RAM[25] !== dat[1]) begin failures++; $display("[TB] FAIL b2b_pop2 got=%h want=%h", dut.RAM[25], dat[1]); end
            end
        end
        settle(16);
    endtask

    task automatic test_read_after_writes();
        int waitCycles;
        int lat;
        logic [31:0] got;
        settle(4);
        driveCycle(1'b1, 1'b1, 32'h64, 32'h19);
        driveCycle(1'b1, 1'b1, 32'h68, 32'h2A);
        waitCycles = 0;
        do begin
            driveCycle(1'b1, 1'b0, 32'h64, 32'h0);
            checks++; if (obsReady !== expReady) begin failures++; $display("[TB] FAIL raw_ready got=%b want=%b", obsReady, expReady); end
            waitCycles++;
        end while (!expReady && waitCycles < 20);
        checks++; if (waitCycles != 4) begin failures++; $display("[TB] FAIL raw_accept_cycle got=%0d want=4", waitCycles); end
        lat = -1;
        got = 32'h0;
        for (int j = 1; j <= 6; j++) begin
            driveCycle(1'b0, 1'b0, 32'h0, 32'h0);
            if (obsValid === 1'b1 && lat < 0) begin lat = j; got = obsData; end
        end
        checks++; if (lat != 3) begin failures++; $display("[TB] FAIL raw_latency got=%0d want=3", lat); end
        checks++; if (got !== 32'h19) begin failures++; $display("[TB] FAIL raw_data got=%h want=19", got); end
    endtask

    task automatic test_misaligned();
        logic [31:0] old24;
        settle(4);
        driveCycle(1'b1, 1'b0, 32'h61, 32'h0);
        checks++; if (obsReady !== 1'b1) begin failures++; $display("[TB] FAIL misrd_ready got=%b want=1", obsReady); end
        for (int j = 1; j <= 5; j++) begin
            driveCycle(1'b0, 1'b0, 32'h0, 32'h0);
            if (j == 3) begin
                checks++; if (obsValid !== 1'b1) begin failures++; $display("[TB] FAIL misrd_valid got=%b want=1", obsValid); end
                checks++; if (obsErr !== 1'b1) begin failures++; $display("[TB] FAIL misrd_err got=%b want=1", obsErr); end
                checks++; if (obsData !== 32'h0) begin failures++; $display("[TB] FAIL misrd_data got=%h want=0", obsData); end
            end else begin
                checks++; if ({obsValid, obsErr} !== 2'b00) begin failures++; $display("[TB] FAIL misrd_quiet cycle=%0d got=%b%b want=00", j, obsValid, obsErr); end
            end
        end
        old24 = mram[24];
        driveCycle(1'b1, 1'b1, 32'h62, ~old24);
        checks++; if (obsReady !== 1'b1) begin failures++; $display("[TB] FAIL miswr_ready got=%b want=1", obsReady); end
        driveCycle(1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (obsErr !== 1'b1) begin failures++; $display("[TB] FAIL miswr_err got=%b want=1", obsErr); end
        driveCycle(1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (obsErr !== 1'b0) begin failures++; $display("[TB] FAIL miswr_err_pulse got=%b want=0", obsErr); end
        settle(6);
        checks++; if (dut.RAM[24] !== old24) begin failures++; $display("[TB] FAIL miswr_ram got=%h want=%h", dut.RAM[24], old24); end
    endtask

    task automatic test_reset_midop();
        logic [31:0] old [0:3];
        int seen;
        int lat;
        logic [31:0] got;
        settle(4);
        driveCycle(1'b1, 1'b0, 32'h64, 32'h0);
        checks++; if (obsReady !== 1'b1) begin failures++; $display("[TB] FAIL rstrd_ready got=%b want=1", obsReady); end
        applyReset();
        checks++; if (ReadData !== 32'h0) begin failures++; $display("[TB] FAIL rstrd_data got=%h want=0", ReadData); end
        seen = 0;
        for (int j = 0; j < 8; j++) begin
            driveCycle(1'b0, 1'b0, 32'h0, 32'h0);
            if (obsValid !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("[TB] FAIL rstrd_novalid got=%0d want=0", seen); end
        for (int k = 0; k < 4; k++) old[k] = mram[40 + k];
        for (int k = 0; k < 4; k++) begin
            driveCycle(1'b1, 1'b1, 32'hA0 + 32'(4 * k), ~old[k]);
            checks++; if (obsReady !== 1'b1) begin failures++; $display("[TB] FAIL rstwr_ready k=%0d got=%b want=1", k, obsReady); end
        end
        applyReset();
        checks++; if (dut.RAM[40] !== ~old[0]) begin failures++; $display("[TB] FAIL rstwr_drained got=%h want=%h", dut.RAM[40], ~old[0]); end
        for (int k = 1; k < 4; k++) begin
            checks++; if (dut.RAM[40 + k] !== old[k]) begin failures++; $display("[TB] FAIL rstwr_discard word=%0d got=%h want=%h", 40 + k, dut.RAM[40 + k], old[k]); end
        end
        driveCycle(1'b1, 1'b0, 32'hA4, 32'h0);
        checks++; if (obsReady !== 1'b1) begin failures++; $display("[TB] FAIL rstwr_empty_ready got=%b want=1", obsReady); end
        lat = -1;
        got = 32'h0;
        for (int j = 1; j <= 6; j++) begin
            driveCycle(1'b0, 1'b0, 32'h0, 32'h0);
            if (obsValid === 1'b1 && lat < 0) begin lat = j; got = obsData; end
        end
        checks++; if (lat != 3 || got !== old[1]) begin failures++; $display("[TB] FAIL rstwr_read lat=%0d got=%h want lat=3 data=%h", lat, got, old[1]); end
    endtask

    task automatic test_alias();
        settle(2);
        driveCycle(1'b1, 1'b1, 32'h160, 32'hAB);
        checks++; if (obsReady !== 1'b1) begin failures++; $display("[TB] FAIL alias_ready got=%b want=1", obsReady); end
        settle(6);
        checks++; if (dut.RAM[24] !== 32'hAB) begin failures++; $display("[TB] FAIL alias_ram got=%h want=000000ab", dut.RAM[24]); end
    endtask

    task automatic test_random();
        logic        req, wr;
        logic [31:0] adr, data;
        for (int i = 0; i < 400; i++) begin
            req  = ($urandom_range(0, 9) < 7);
            wr   = $urandom_range(0, 1) == 1;
            adr  = $urandom;
            data = $urandom;
            if ($urandom_range(0, 7) != 0) adr[1:0] = 2'b00;
            driveCycle(req, wr, adr, data);
            checks++; if (obsReady !== expReady) begin failures++; $display("[TB] FAIL rnd_ready cyc=%0d got=%b want=%b", cyc, obsReady, expReady); end
            checks++; if (obsValid !== expValid) begin failures++; $display("[TB] FAIL rnd_valid cyc=%0d got=%b want=%b", cyc, obsValid, expValid); end
            checks++; if (obsErr !== expErr) begin failures++; $display("[TB] FAIL rnd_adrerr cyc=%0d got=%b want=%b", cyc, obsErr, expErr); end
            checks++; if (obsData !== expData) begin failures++; $display("[TB] FAIL rnd_data cyc=%0d got=%h want=%h", cyc, obsData, expData); end
        end
        settle(20);
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (dut.RAM[i] !== mram[i]) begin failures++; $display("[TB] FAIL rnd_ram word=%0d got=%h want=%h", i, dut.RAM[i], mram[i]); end
        end
    endtask

    initial begin
        reset = 1'b1; MemReq = 1'b0; MemWrite = 1'b0; DataAdr = 32'h0; WriteData = 32'h0;
        test_reset();
        test_preload();
        test_single_write();
        test_back_to_back();
        test_read_after_writes();
        test_misaligned();
        test_reset_midop();
        test_alias();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
